// File: rtl/dg0040_pkg.sv
// Shared definitions for the DG0040 program sequencer and return stack.
// Holds the opcode map, the PC field widths and the word-counter LFSR step.
package dg0040_pkg;

  localparam int PAGE_W = 4;
  localparam int WORD_W = 6;
  localparam int PC_W   = PAGE_W + WORD_W;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_LDP  = 3'b010;
  localparam logic [2:0] OP_BR   = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;

  // XNOR feedback gives a 63-state cycle; all-ones is the lock state.
  function automatic logic [WORD_W-1:0] lfsr_next(input logic [WORD_W-1:0] w);
    return {~(w[1] ^ w[0]), w[WORD_W-1:1]};
  endfunction

endpackage

// File: rtl/dg0040_poly_counter.sv
// 6-bit polynomial word counter with hold, step and parallel load.
// Load has priority over step; next_o exposes the successor of the current word.
module dg0040_poly_counter
  import dg0040_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_WORD = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              step_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] load_val_i,
  output logic [WORD_W-1:0] word_o,
  output logic [WORD_W-1:0] next_o
);

  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] word_d;

  always_comb begin
    word_d = word_q;
    if (load_i) begin
      word_d = load_val_i;
    end else if (step_i) begin
      word_d = lfsr_next(word_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= RESET_WORD;
    end else begin
      word_q <= word_d;
    end
  end

  assign word_o = word_q;
  assign next_o = lfsr_next(word_q);

endmodule

// File: rtl/dg0040_pc_sequencer.sv
// Program-address sequencer feeding the DG0040 return-address stack.
// Owns page/word PC, the page buffer, stack depth tracking and stack control decode.
module dg0040_pc_sequencer
  import dg0040_pkg::*;
#(
  parameter int               STACK_DEPTH = 5,
  parameter logic [PC_W-1:0]  RESET_PC    = 10'h000
) (
  input  logic              CLK,
  input  logic              NRST,
  input  logic              OP_VALID,
  input  logic [2:0]        OP,
  input  logic [WORD_W-1:0] ADDR,
  input  logic [PAGE_W-1:0] PAGE_IN,
  input  logic [PC_W-1:0]   SP,
  input  logic              CLR_ERR,
  output logic [PC_W-1:0]   PC,
  output logic [PC_W-1:0]   PUSH_ADDR,
  output logic              MODE1,
  output logic              MODE0,
  output logic [2:0]        DEPTH,
  output logic              STK_OVF,
  output logic              STK_UNF
);

  localparam logic [2:0] DEPTH_MAX = 3'(STACK_DEPTH);

  // OP is only meaningful when OP_VALID is high; otherwise the cycle is a NOP.
  // There is no back-pressure: every valid op takes effect on the next edge.
  logic [2:0] op_eff;
  logic       is_inc, is_ldp, is_br, is_call, is_ret;

  assign op_eff  = OP_VALID ? OP : OP_NOP;
  assign is_inc  = (op_eff == OP_INC);
  assign is_ldp  = (op_eff == OP_LDP);
  assign is_br   = (op_eff == OP_BR);
  assign is_call = (op_eff == OP_CALL);
  assign is_ret  = (op_eff == OP_RET);

  logic [PAGE_W-1:0] page_q, page_d;
  logic [PAGE_W-1:0] pb_q, pb_d;
  logic [2:0]        depth_q, depth_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic [WORD_W-1:0] word;
  logic [WORD_W-1:0] word_next;
  logic              word_step;
  logic              word_load;
  logic [WORD_W-1:0] word_load_val;

  assign word_step     = is_inc | is_ldp;
  assign word_load     = is_br | is_call | is_ret;
  assign word_load_val = is_ret ? SP[WORD_W-1:0] : ADDR;

  dg0040_poly_counter #(
    .RESET_WORD (RESET_PC[WORD_W-1:0])
  ) u_word (
    .clk_i      (CLK),
    .rst_ni     (NRST),
    .step_i     (word_step),
    .load_i     (word_load),
    .load_val_i (word_load_val),
    .word_o     (word),
    .next_o     (word_next)
  );

  always_comb begin
    page_d = page_q;
    pb_d   = pb_q;
    if (is_br || is_call) begin
      page_d = pb_q;
    end else if (is_ret) begin
      page_d = SP[PC_W-1:WORD_W];
      pb_d   = SP[PC_W-1:WORD_W];
    end else if (is_ldp) begin
      pb_d = PAGE_IN;
    end
  end

  // A fresh error in the same cycle as CLR_ERR leaves the flag set.
  always_comb begin
    depth_d = depth_q;
    ovf_d   = ovf_q & ~CLR_ERR;
    unf_d   = unf_q & ~CLR_ERR;
    if (is_call) begin
      if (depth_q < DEPTH_MAX) begin
        depth_d = depth_q + 3'd1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (is_ret) begin
      if (depth_q != 3'd0) begin
        depth_d = depth_q - 3'd1;
      end else begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      page_q  <= RESET_PC[PC_W-1:WORD_W];
      pb_q    <= RESET_PC[PC_W-1:WORD_W];
      depth_q <= 3'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      page_q  <= page_d;
      pb_q    <= pb_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack controls are combinational so the stack acts on the same edge.
  assign MODE1     = NRST & (is_call | is_ret);
  assign MODE0     = NRST & is_ret;
  assign PUSH_ADDR = {page_q, word_next};
  assign PC        = {page_q, word};
  assign DEPTH     = depth_q;
  assign STK_OVF   = ovf_q;
  assign STK_UNF   = unf_q;

endmodule

// File: tb/tb_dg0040_pc_sequencer.sv
// Self-checking bench for dg0040_pc_sequencer against a behavioural PC/stack-depth model.
// Directed scenarios first, then randomized op streams.
module tb_dg0040_pc_sequencer;

  logic       CLK;
  logic       NRST;
  logic       OP_VALID;
  logic [2:0] OP;
  logic [5:0] ADDR;
  logic [3:0] PAGE_IN;
  logic [9:0] SP;
  logic       CLR_ERR;
  logic [9:0] PC;
  logic [9:0] PUSH_ADDR;
  logic       MODE1;
  logic       MODE0;
  logic [2:0] DEPTH;
  logic       STK_OVF;
  logic       STK_UNF;

  int n_checks = 0;
  int n_fail   = 0;

  dg0040_pc_sequencer dut (
    .CLK       (CLK),
    .NRST      (NRST),
    .OP_VALID  (OP_VALID),
    .OP        (OP),
    .ADDR      (ADDR),
    .PAGE_IN   (PAGE_IN),
    .SP        (SP),
    .CLR_ERR   (CLR_ERR),
    .PC        (PC),
    .PUSH_ADDR (PUSH_ADDR),
    .MODE1     (MODE1),
    .MODE0     (MODE0),
    .DEPTH     (DEPTH),
    .STK_OVF   (STK_OVF),
    .STK_UNF   (STK_UNF)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  int m_page, m_pb, m_word, m_depth;
  bit m_ovf, m_unf;
  localparam int MAX_DEPTH = 5;

  function automatic int ref_lfsr(input int w);
    int b0, b1, fb;
    b0 = w % 2;
    b1 = (w / 2) % 2;
    fb = (b0 == b1) ? 1 : 0;
    return fb * 32 + w / 2;
  endfunction

  function automatic logic [9:0] ref_pc();
    return 10'(m_page * 64 + m_word);
  endfunction

  function automatic logic [1:0] ref_mode(input logic v, input logic [2:0] op);
    if (!v) return 2'b00;
    if (op == 3'd4) return 2'b10;
    if (op == 3'd5) return 2'b11;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_page = 0; m_pb = 0; m_word = 0; m_depth = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_step(input logic v, input logic [2:0] op, input logic [5:0] addr,
                            input logic [3:0] page, input logic [9:0] sp, input logic clr);
    bit new_ovf, new_unf;
    int eff;
    new_ovf = 0; new_unf = 0;
    eff = v ? int'(op) : 0;
    case (eff)
      1: m_word = ref_lfsr(m_word);
      2: begin m_pb = int'(page); m_word = ref_lfsr(m_word); end
      3: begin m_page = m_pb; m_word = int'(addr); end
      4: begin
        m_page = m_pb; m_word = int'(addr);
        if (m_depth < MAX_DEPTH) m_depth++; else new_ovf = 1;
      end
      5: begin
        m_page = int'(sp) / 64; m_pb = m_page; m_word = int'(sp) % 64;
        if (m_depth > 0) m_depth--; else new_unf = 1;
      end
      default: ;
    endcase
    m_ovf = (m_ovf && !clr) || new_ovf;
    m_unf = (m_unf && !clr) || new_unf;
  endtask

  // ---------------- driver ----------------
  logic [1:0] obs_mode, exp_mode;
  logic [9:0] obs_push, exp_push;

  task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] addr,
                       input logic [3:0] page, input logic [9:0] sp, input logic clr);
    @(negedge CLK);
    OP_VALID = v; OP = op; ADDR = addr; PAGE_IN = page; SP = sp; CLR_ERR = clr;
    #1;
    obs_mode = {MODE1, MODE0};
    obs_push = PUSH_ADDR;
    exp_mode = ref_mode(v, op);
    exp_push = 10'(m_page * 64 + ref_lfsr(m_word));
    @(posedge CLK);
    model_step(v, op, addr, page, sp, clr);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 6'd0, 4'd0, 10'd0, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    NRST = 1'b0; OP_VALID = 1'b1; OP = 3'd4; ADDR = 6'h11; PAGE_IN = 4'h0; SP = 10'h0; CLR_ERR = 1'b0;
    #1;
    n_checks++;
    if ({MODE1, MODE0} !== 2'b00) begin n_fail++; $display("FAIL reset_mode: got %b want 00", {MODE1, MODE0}); end
    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    n_checks++;
    if (PC !== ref_pc()) begin n_fail++; $display("FAIL reset_pc: got %h want %h", PC, ref_pc()); end
    n_checks++;
    if (DEPTH !== 3'd0 || STK_OVF !== 1'b0 || STK_UNF !== 1'b0) begin
      n_fail++; $display("FAIL reset_status: got d=%0d o=%b u=%b want 0 0 0", DEPTH, STK_OVF, STK_UNF);
    end
    @(negedge CLK);
    OP_VALID = 1'b0;
    NRST = 1'b1;
  endtask

  task automatic test_inc();
    logic [5:0] tab [7];
    tab = '{6'h20, 6'h30, 6'h38, 6'h3C, 6'h3E, 6'h1F, 6'h2F};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 3'd1, 6'd0, 4'd0, 10'd0, 1'b0);
      n_checks++;
      if (PC !== {4'd0, tab[i]} || PC !== ref_pc()) begin
        n_fail++; $display("FAIL inc_pc[%0d]: got %h want %h", i, PC, {4'd0, tab[i]});
      end
      n_checks++;
      if (obs_mode !== 2'b00) begin n_fail++; $display("FAIL inc_mode[%0d]: got %b want 00", i, obs_mode); end
    end
  endtask

  task automatic test_ldp_br();
    drive(1'b1, 3'd2, 6'd0, 4'd3, 10'd0, 1'b0);
    n_checks++;
    if (PC !== ref_pc()) begin n_fail++; $display("FAIL ldp_pc: got %h want %h", PC, ref_pc()); end
    drive(1'b1, 3'd3, 6'h15, 4'd0, 10'd0, 1'b0);
    n_checks++;
    if (PC !== 10'h0D5) begin n_fail++; $display("FAIL br_pc: got %h want 0d5", PC); end
  endtask

  task automatic test_call_ret();
    logic [9:0] pushed;
    drive(1'b1, 3'd4, 6'h01, 4'd0, 10'd0, 1'b0);
    pushed = exp_push;
    n_checks++;
    if (obs_push !== exp_push) begin n_fail++; $display("FAIL call_push: got %h want %h", obs_push, exp_push); end
    n_checks++;
    if (obs_mode !== 2'b10) begin n_fail++; $display("FAIL call_mode: got %b want 10", obs_mode); end
    n_checks++;
    if (PC !== 10'h0C1 || DEPTH !== 3'd1) begin
      n_fail++; $display("FAIL call_state: got pc=%h d=%0d want 0c1 1", PC, DEPTH);
    end
    drive(1'b1, 3'd5, 6'd0, 4'd0, pushed, 1'b0);
    n_checks++;
    if (obs_mode !== 2'b11) begin n_fail++; $display("FAIL ret_mode: got %b want 11", obs_mode); end
    n_checks++;
    if (PC !== pushed || DEPTH !== 3'd0) begin
      n_fail++; $display("FAIL ret_state: got pc=%h d=%0d want %h 0", PC, DEPTH, pushed);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 3'd4, 6'($urandom_range(0, 62)), 4'd0, 10'd0, 1'b0);
      n_checks++;
      if (DEPTH !== 3'(m_depth) || STK_OVF !== m_ovf || PC !== ref_pc()) begin
        n_fail++; $display("FAIL ovf_call[%0d]: got d=%0d o=%b pc=%h want %0d %b %h",
                           i, DEPTH, STK_OVF, PC, m_depth, m_ovf, ref_pc());
      end
    end
    n_checks++;
    if (DEPTH !== 3'd5 || STK_OVF !== 1'b1) begin
      n_fail++; $display("FAIL ovf_flag: got d=%0d o=%b want 5 1", DEPTH, STK_OVF);
    end
    drive(1'b0, 3'd0, 6'd0, 4'd0, 10'd0, 1'b1);
    n_checks++;
    if (STK_OVF !== 1'b0 || DEPTH !== 3'd5) begin
      n_fail++; $display("FAIL ovf_clear: got o=%b d=%0d want 0 5", STK_OVF, DEPTH);
    end
    for (int i = 0; i < 5; i++) drive(1'b1, 3'd5, 6'd0, 4'd0, 10'($urandom_range(0, 1023)), 1'b0);
    n_checks++;
    if (DEPTH !== 3'd0 || STK_UNF !== 1'b0) begin
      n_fail++; $display("FAIL ovf_drain: got d=%0d u=%b want 0 0", DEPTH, STK_UNF);
    end
  endtask

  task automatic test_underflow();
    drive(1'b1, 3'd5, 6'd0, 4'd0, 10'h155, 1'b0);
    n_checks++;
    if (PC !== 10'h155 || STK_UNF !== 1'b1 || DEPTH !== 3'd0) begin
      n_fail++; $display("FAIL unf_ret: got pc=%h u=%b d=%0d want 155 1 0", PC, STK_UNF, DEPTH);
    end
    drive(1'b1, 3'd5, 6'd0, 4'd0, 10'h0AA, 1'b1);
    n_checks++;
    if (STK_UNF !== 1'b1 || PC !== 10'h0AA) begin
      n_fail++; $display("FAIL unf_clr_race: got u=%b pc=%h want 1 0aa", STK_UNF, PC);
    end
    drive(1'b0, 3'd0, 6'd0, 4'd0, 10'd0, 1'b1);
    n_checks++;
    if (STK_UNF !== 1'b0) begin n_fail++; $display("FAIL unf_clear: got %b want 0", STK_UNF); end
  endtask

  task automatic test_reset_mid();
    logic [9:0] held;
    drive(1'b1, 3'd4, 6'h2A, 4'd0, 10'd0, 1'b0);
    @(negedge CLK);
    OP_VALID = 1'b1; OP = 3'd4; ADDR = 6'h07;
    #1;
    n_checks++;
    if ({MODE1, MODE0} !== 2'b10) begin n_fail++; $display("FAIL mid_pre_mode: got %b want 10", {MODE1, MODE0}); end
    NRST = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({MODE1, MODE0} !== 2'b00) begin n_fail++; $display("FAIL mid_mode: got %b want 00", {MODE1, MODE0}); end
    n_checks++;
    if (PC !== ref_pc() || DEPTH !== 3'd0) begin
      n_fail++; $display("FAIL mid_state: got pc=%h d=%0d want %h 0", PC, DEPTH, ref_pc());
    end
    @(negedge CLK);
    OP_VALID = 1'b0;
    NRST = 1'b1;
    held = PC;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 3'($urandom_range(0, 7)), 6'($urandom), 4'($urandom), 10'($urandom), 1'b0);
      n_checks++;
      if (PC !== held || obs_mode !== 2'b00) begin
        n_fail++; $display("FAIL idle_pc[%0d]: got pc=%h m=%b want %h 00", i, PC, obs_mode, held);
      end
    end
  endtask

  logic [9:0] exp_q[$];

  task automatic test_random();
    logic [9:0] want;
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)), 6'($urandom_range(0, 63)),
            4'($urandom), 10'($urandom), ($urandom_range(0, 7) == 0));
      exp_q.push_back(ref_pc());
      want = exp_q.pop_front();
      n_checks++;
      if (PC !== want || DEPTH !== 3'(m_depth) || STK_OVF !== m_ovf || STK_UNF !== m_unf) begin
        n_fail++; $display("FAIL rand_state[%0d]: got pc=%h d=%0d o=%b u=%b want %h %0d %b %b",
                           i, PC, DEPTH, STK_OVF, STK_UNF, want, m_depth, m_ovf, m_unf);
      end
      n_checks++;
      if (obs_mode !== exp_mode || obs_push !== exp_push) begin
        n_fail++; $display("FAIL rand_ctrl[%0d]: got m=%b push=%h want %b %h",
                           i, obs_mode, obs_push, exp_mode, exp_push);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    model_reset();
    test_reset();
    test_inc();
    test_ldp_br();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
